branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
- Program-counter and branch-redirect stage that consumes the branch comparator's 1-bit taken flag (jmpTrue) in the ID stage.
- Owns the architectural PC register.
- Computes the PC-relative branch target and the register-jump target.
- Generates the IF/ID flush and a HALT freeze, and keeps saturating branch and taken-branch statistics for the bench and debug.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_INC, 2, sequential PC increment in bytes (16-bit instructions).
- OFF_W, 12, width of the signed branch offset field, in instruction units.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rstN, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
- stall, input, 1, hazard unit hold; the PC and counters freeze.
- branchValid, input, 1, conditional branch in ID (branch op nonzero).
- jmpTrue, input, 1, comparator taken flag for the branch in ID.
- jumpValid, input, 1, unconditional register jump in ID.
- idPc, input, 16, PC of the instruction currently in ID.
- offset, input, OFF_W, signed branch offset in instruction units.
- jumpReg, input, 16, register value used as the absolute jump target.
- haltReq, input, 1, HALT instruction in ID.
- pc, output, 16, current fetch PC.
- flushIfId, output, 1, squash the IF/ID register at the next edge.
- redirect, output, 1, PC is loading a non-sequential target this cycle.
- halted, output, 1, unit is in the HALT state.
- branchCnt, output, 16, number of conditional branches resolved.
- takenCnt, output, 16, number of conditional branches taken.

Behaviour:
- Reset (rstN low at a rising edge):
  - pc = RESET_PC, state = RUN, branchCnt = 0, takenCnt = 0.
  - Reset overrides everything, including a cycle mid-redirect or in HALT.
- States: RUN, REDIRECT, HALT.
  - halted = (state == HALT).
  - The state is registered.
- Target arithmetic (all modulo 2^16, no overflow flag):
  - brTarget = idPc + (sign-extend(offset) << 1).
  - jTarget = {jumpReg[15:1], 1'b0}; bit 0 is forced to 0.
- Combinational decode in RUN, with priority haltReq > stall > jumpValid > branchValid.
  - takeBr = branchValid & jmpTrue & ~stall & ~haltReq.
  - takeJ = jumpValid & ~stall & ~haltReq.
  - redirect = takeBr | takeJ.
  - flushIfId = redirect.
  - flushIfId and redirect are 0 in REDIRECT and HALT.
- Next PC in RUN:
  - haltReq: pc holds; next state = HALT.
  - stall: pc holds; no flush; the branch is re-evaluated next cycle because ID holds.
  - takeJ: pc <= jTarget; next state = REDIRECT.
  - takeBr: pc <= brTarget; next state = REDIRECT.
  - otherwise: pc <= pc + PC_INC.
- REDIRECT lasts one cycle.
  - ID holds the flushed bubble, so branchValid, jumpValid and haltReq are ignored.
  - pc <= pc + PC_INC unless stall, in which case pc holds and the state stays REDIRECT.
  - Next state is RUN.
- HALT:
  - pc frozen; all inputs ignored; counters frozen.
  - The only exit is reset.
- Counters, updated in RUN only and only when ~stall & ~haltReq & branchValid:
  - branchCnt += 1.
  - takenCnt += 1 if jmpTrue.
  - Both saturate at 16'hFFFF; they do not wrap.
  - jumpValid does not count.
- Simultaneous jumpValid and branchValid is illegal upstream; the jump wins and branchCnt still counts.
- Latency:
  - Redirect takes one cycle: the target appears on pc the cycle after resolution.
  - Exactly one wrong-path fetch occurs, which flushIfId squashes.

Decomposition:
- Shared package:
  - state encoding constants ST_RUN = 2'd0, ST_REDIRECT = 2'd1, ST_HALT = 2'd2.
  - PC_W = 16 and the RESET_PC default, shared with the fetch and IF/ID stages.
- One natural sub-module, sat_counter16 (enable, clear, saturating increment), instantiated twice for branchCnt and takenCnt.
- The target adder stays inline.

Test Plan:
- Reset with RESET_PC=16'h0100, rstN held low for 2 cycles, then released -> pc=0100, then 0102, 0104 on successive cycles; counters 0; flushIfId 0.
- Branch taken: idPc=0104, offset=12'hFFE (−2), branchValid=1, jmpTrue=1 -> flushIfId=1 that cycle; next pc=0100; state REDIRECT for one cycle, then pc=0102; branchCnt=1, takenCnt=1.
- Not-taken, then stall collision:
  - branchValid=1 with jmpTrue=0 -> pc+2 sequence and branchCnt increments only.
  - Repeat with stall=1 and jmpTrue=1 for 2 cycles -> pc holds, no flush, no count.
  - When stall drops -> redirect occurs once and branchCnt increments once.
- Register jump with jumpReg=16'h3A07 -> pc=3A06 next cycle; flushIfId=1 for exactly one cycle; counters unchanged.
- Wrap and saturate: idPc=FFFE with offset=+2 -> pc=0002. Preload counters at FFFF, then take a branch -> both remain FFFF.
- Halt: haltReq=1 at pc=0200 -> halted=1 and pc frozen; later branch and jump inputs ignored; rstN low for one edge -> pc=RESET_PC, halted=0.

Source files
------------

// File: rtl/branch_pc_unit_pkg.sv
// Shared PC-stage definitions: state encoding, PC width and reset vector,
// reused by the fetch and IF/ID stages.
package branch_pc_unit_pkg;

  localparam int PC_W = 16;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  // Instructions are halfword aligned, so a register target drops bit 0.
  function automatic logic [PC_W-1:0] align_halfword(input logic [PC_W-1:0] addr);
    return addr & 16'hFFFE;
  endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// ID-stage to PC-unit bundle: branch/jump/halt requests in, PC, flush and
// statistics out. The ID stage is the master, the PC unit the slave.
interface branch_pc_unit_if #(
  parameter int OFF_W = 12
) ();
  import branch_pc_unit_pkg::*;

  logic             stall;
  logic             branchValid;
  logic             jmpTrue;
  logic             jumpValid;
  logic [PC_W-1:0]  idPc;
  logic [OFF_W-1:0] offset;
  logic [PC_W-1:0]  jumpReg;
  logic             haltReq;
  logic [PC_W-1:0]  pc;
  logic             flushIfId;
  logic             redirect;
  logic             halted;
  logic [15:0]      branchCnt;
  logic [15:0]      takenCnt;

  modport master (
    output stall, branchValid, jmpTrue, jumpValid, idPc, offset, jumpReg, haltReq,
    input  pc, flushIfId, redirect, halted, branchCnt, takenCnt
  );

  modport slave (
    input  stall, branchValid, jmpTrue, jumpValid, idPc, offset, jumpReg, haltReq,
    output pc, flushIfId, redirect, halted, branchCnt, takenCnt
  );

endinterface

// File: rtl/branch_pc_unit_sat_counter16.sv
// 16-bit event counter with synchronous clear that sticks at 16'hFFFF
// instead of wrapping.
module sat_counter16
  import branch_pc_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rstN,
  input  logic        en_i,
  input  logic        clr_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: clear wins, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 16'h0000;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 16'h0001;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_pc_unit.sv
// Architectural PC with one-cycle branch/jump redirect, IF/ID flush,
// HALT freeze and saturating branch statistics.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              PC_INC   = 2,
  parameter int              OFF_W    = 12
) (
  input logic             clk,
  input logic             rstN,
  branch_pc_unit_if.slave bus
);

  state_e          state_q;
  state_e          state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  logic            take_br_s;
  logic            take_j_s;
  logic            br_cnt_en_s;
  logic            tk_cnt_en_s;
  logic [PC_W-1:0] off_ext_s;
  logic [PC_W-1:0] br_target_s;
  logic [PC_W-1:0] j_target_s;
  logic [PC_W-1:0] pc_seq_s;

  // Offsets are in instruction units, hence the shift to bytes.
  assign off_ext_s   = {{(PC_W-OFF_W){bus.offset[OFF_W-1]}}, bus.offset};
  assign br_target_s = bus.idPc + (off_ext_s << 1);
  assign j_target_s  = align_halfword(bus.jumpReg);
  assign pc_seq_s    = pc_q + PC_W'(PC_INC);

  // Decode and next-state/next-PC selection.
  always_comb begin
    take_br_s   = 1'b0;
    take_j_s    = 1'b0;
    br_cnt_en_s = 1'b0;
    tk_cnt_en_s = 1'b0;
    state_d     = state_q;
    pc_d        = pc_q;
    case (state_q)
      ST_RUN: begin
        take_br_s   = bus.branchValid & bus.jmpTrue & ~bus.stall & ~bus.haltReq;
        take_j_s    = bus.jumpValid & ~bus.stall & ~bus.haltReq;
        br_cnt_en_s = bus.branchValid & ~bus.stall & ~bus.haltReq;
        tk_cnt_en_s = br_cnt_en_s & bus.jmpTrue;
        if (bus.haltReq) begin
          state_d = ST_HALT;
        end else if (bus.stall) begin
          state_d = ST_RUN;
        end else if (take_j_s) begin
          pc_d    = j_target_s;
          state_d = ST_REDIRECT;
        end else if (take_br_s) begin
          pc_d    = br_target_s;
          state_d = ST_REDIRECT;
        end else begin
          pc_d    = pc_seq_s;
        end
      end
      ST_REDIRECT: begin
        // ID holds the squashed bubble here, so its requests are ignored.
        if (bus.stall) begin
          state_d = ST_REDIRECT;
        end else begin
          pc_d    = pc_seq_s;
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // PC and state registers.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  sat_counter16 u_branch_cnt (
    .clk   (clk),
    .rstN  (rstN),
    .en_i  (br_cnt_en_s),
    .clr_i (1'b0),
    .cnt_o (bus.branchCnt)
  );

  sat_counter16 u_taken_cnt (
    .clk   (clk),
    .rstN  (rstN),
    .en_i  (tk_cnt_en_s),
    .clr_i (1'b0),
    .cnt_o (bus.takenCnt)
  );

  assign bus.pc        = pc_q;
  assign bus.redirect  = take_br_s | take_j_s;
  assign bus.flushIfId = take_br_s | take_j_s;
  assign bus.halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed and random stimulus for branch_pc_unit, checked every cycle
// against an arithmetic model of the PC/redirect/halt rules.
module tb_branch_pc_unit;

  localparam logic [15:0] RST_PC = 16'h0100;

  logic clk;
  logic rstN;
  int   tests;
  int   fails;

  // Model state.
  int   m_pc;
  bit   m_halt;
  bit   m_pend;
  int   m_bc;
  int   m_tc;
  int   halt_cycles;

  branch_pc_unit_if #(.OFF_W(12)) bus_if ();

  branch_pc_unit #(.RESET_PC(RST_PC), .PC_INC(2), .OFF_W(12)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_redirect();
    if (m_halt || m_pend || bus_if.haltReq || bus_if.stall) return 1'b0;
    return bus_if.jumpValid || (bus_if.branchValid && bus_if.jmpTrue);
  endfunction

  task automatic check_all();
    chk("pc",        bus_if.pc,                      16'(m_pc));
    chk("flushIfId", {15'd0, bus_if.flushIfId},      {15'd0, exp_redirect()});
    chk("redirect",  {15'd0, bus_if.redirect},       {15'd0, exp_redirect()});
    chk("halted",    {15'd0, bus_if.halted},         {15'd0, m_halt});
    chk("branchCnt", bus_if.branchCnt,               16'(m_bc));
    chk("takenCnt",  bus_if.takenCnt,                16'(m_tc));
  endtask

  task automatic model_update();
    int off;
    if (!rstN) begin
      m_pc = int'(RST_PC); m_halt = 1'b0; m_pend = 1'b0; m_bc = 0; m_tc = 0;
    end else if (m_halt) begin
      m_halt = 1'b1;
    end else if (m_pend) begin
      if (!bus_if.stall) begin
        m_pc   = (m_pc + 2) % 65536;
        m_pend = 1'b0;
      end
    end else if (bus_if.haltReq) begin
      m_halt = 1'b1;
    end else if (!bus_if.stall) begin
      if (bus_if.branchValid) begin
        if (m_bc < 65535) m_bc++;
        if (bus_if.jmpTrue && m_tc < 65535) m_tc++;
      end
      off = int'(bus_if.offset);
      if (off >= 2048) off -= 4096;
      if (bus_if.jumpValid) begin
        m_pc   = int'(bus_if.jumpReg) - (int'(bus_if.jumpReg) % 2);
        m_pend = 1'b1;
      end else if (bus_if.branchValid && bus_if.jmpTrue) begin
        m_pc   = (int'(bus_if.idPc) + 2 * off + 65536) % 65536;
        m_pend = 1'b1;
      end else begin
        m_pc   = (m_pc + 2) % 65536;
      end
    end
  endtask

  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    bus_if.stall = 1'b0; bus_if.branchValid = 1'b0; bus_if.jmpTrue = 1'b0;
    bus_if.jumpValid = 1'b0; bus_if.haltReq = 1'b0;
    bus_if.idPc = 16'h0000; bus_if.offset = 12'h000; bus_if.jumpReg = 16'h0000;
  endtask

  task automatic branch(input logic [15:0] id_pc, input logic [11:0] off, input logic taken);
    bus_if.branchValid = 1'b1; bus_if.jmpTrue = taken;
    bus_if.idPc = id_pc; bus_if.offset = off;
  endtask

  initial begin
    tests = 0; fails = 0; halt_cycles = 0;
    rstN = 1'b0;
    idle();
    @(negedge clk);
    @(posedge clk);
    model_update();
    @(negedge clk);
    step();
    chk("lit_reset_pc", bus_if.pc, 16'h0100);
    chk("lit_reset_cnt", bus_if.branchCnt, 16'h0000);
    rstN = 1'b1;
    step();
    chk("lit_seq_0102", bus_if.pc, 16'h0102);
    step();
    chk("lit_seq_0104", bus_if.pc, 16'h0104);

    // Taken backward branch.
    branch(16'h0104, 12'hFFE, 1'b1);
    #1 chk("lit_br_flush", {15'd0, bus_if.flushIfId}, 16'h0001);
    step();
    idle();
    chk("lit_br_target", bus_if.pc, 16'h0100);
    #1 chk("lit_redir_noflush", {15'd0, bus_if.flushIfId}, 16'h0000);
    step();
    chk("lit_after_redir", bus_if.pc, 16'h0102);
    chk("lit_br_taken_cnt", bus_if.takenCnt, 16'h0001);

    // Not-taken branches, then a stalled taken branch.
    branch(16'h0102, 12'h010, 1'b0);
    step();
    step();
    chk("lit_nt_pc", bus_if.pc, 16'h0106);
    chk("lit_nt_cnt", bus_if.branchCnt, 16'h0003);
    branch(16'h0106, 12'h004, 1'b1);
    bus_if.stall = 1'b1;
    step();
    step();
    chk("lit_stall_pc", bus_if.pc, 16'h0106);
    chk("lit_stall_cnt", bus_if.branchCnt, 16'h0003);
    bus_if.stall = 1'b0;
    step();
    idle();
    chk("lit_unstall_pc", bus_if.pc, 16'h010E);
    chk("lit_unstall_cnt", bus_if.branchCnt, 16'h0004);
    step();

    // Register jump, bit 0 dropped.
    bus_if.jumpValid = 1'b1; bus_if.jumpReg = 16'h3A07;
    step();
    idle();
    chk("lit_jump_pc", bus_if.pc, 16'h3A06);
    step();

    // Target wrap.
    branch(16'hFFFE, 12'h001, 1'b1);
    step();
    idle();
    chk("lit_wrap_pc", bus_if.pc, 16'h0000);
    step();
    branch(16'hFFFE, 12'h002, 1'b1);
    step();
    idle();
    chk("lit_wrap2_pc", bus_if.pc, 16'h0002);
    step();

    // Saturation: preload both counters at the top.
    bus_if.stall = 1'b1;
    force dut.u_branch_cnt.cnt_q = 16'hFFFF;
    force dut.u_taken_cnt.cnt_q  = 16'hFFFF;
    m_bc = 65535; m_tc = 65535;
    step();
    release dut.u_branch_cnt.cnt_q;
    release dut.u_taken_cnt.cnt_q;
    idle();
    branch(bus_if.pc, 12'h008, 1'b1);
    step();
    idle();
    chk("lit_sat_branch", bus_if.branchCnt, 16'hFFFF);
    chk("lit_sat_taken", bus_if.takenCnt, 16'hFFFF);
    step();

    // Halt at 0200 via a jump to 01FE.
    bus_if.jumpValid = 1'b1; bus_if.jumpReg = 16'h01FE;
    step();
    idle();
    step();
    chk("lit_pre_halt_pc", bus_if.pc, 16'h0200);
    bus_if.haltReq = 1'b1;
    step();
    idle();
    chk("lit_halted", {15'd0, bus_if.halted}, 16'h0001);
    branch(16'h0200, 12'h010, 1'b1);
    bus_if.jumpValid = 1'b1; bus_if.jumpReg = 16'h1234;
    step();
    step();
    chk("lit_halt_frozen", bus_if.pc, 16'h0200);
    idle();
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    chk("lit_halt_reset_pc", bus_if.pc, 16'h0100);
    chk("lit_halt_reset_h", {15'd0, bus_if.halted}, 16'h0000);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bus_if.stall       = ($urandom_range(3) == 0);
      bus_if.branchValid = ($urandom_range(2) == 0);
      bus_if.jmpTrue     = $urandom_range(1) != 0;
      bus_if.jumpValid   = ($urandom_range(7) == 0);
      bus_if.haltReq     = ($urandom_range(63) == 0);
      bus_if.idPc        = 16'($urandom);
      bus_if.offset      = 12'($urandom);
      bus_if.jumpReg     = 16'($urandom);
      halt_cycles        = m_halt ? halt_cycles + 1 : 0;
      rstN               = !((halt_cycles > 4) || ($urandom_range(199) == 0));
      step();
    end
    rstN = 1'b1;
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
